// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(parameter int ADDR_W = 32);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed little-endian byte stream into instruction-memory words
module imem_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.master bus,
  output logic         core_hold,
  output logic         done,
  output logic         error,
  output logic [15:0]  words_written
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
  state_t      state;
  logic [15:0] len;
  logic [1:0]  idx;
  logic        xfer;
  logic [16:0] len_nxt;
  assign xfer    = bus.in_valid && bus.in_ready;
  assign len_nxt = {1'b0, bus.in_data, len[7:0]};
  // in_ready is registered, so it is updated together with every state change
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= '0;
      core_hold     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      idx           <= '0;
      len           <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state         <= LEN0;
          bus.in_ready  <= 1'b1;
          bus.mem_addr  <= BASE_ADDR;
          words_written <= '0;
          idx           <= '0;
          done          <= 1'b0;
          error         <= 1'b0;
          core_hold     <= 1'b1;
        end
        LEN0: if (xfer) begin
          len[7:0] <= bus.in_data;
          state    <= LEN1;
        end
        LEN1: if (xfer) begin
          len[15:8] <= bus.in_data;
          if (len_nxt == '0) begin
            state        <= DONE;
            bus.in_ready <= 1'b0;
            done         <= 1'b1;
            core_hold    <= 1'b0;
          end else if (len_nxt > 17'(MAX_WORDS)) begin
            state        <= ERR;
            bus.in_ready <= 1'b0;
            error        <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
          bus.mem_wdata[{idx, 3'b000} +: 8] <= bus.in_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state        <= WRITE;
            bus.in_ready <= 1'b0;
            bus.mem_we   <= 1'b1;
          end
        end
        WRITE: begin
          bus.mem_we    <= 1'b0;
          bus.mem_addr  <= bus.mem_addr + ADDR_W'(4);
          words_written <= words_written + 16'd1;
          if (words_written + 16'd1 == len) begin
            state     <= DONE;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state        <= DATA;
            bus.in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        core_hold, done, error;
  logic [15:0] words_written;
  int          checks = 0;
  int          errors = 0;
  int          rdy_during_we = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stim[$];

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master),
    .core_hold(core_hold), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      if (bus.in_ready) rdy_during_we++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $error("FAIL ready_timeout: observed in_ready=0 for %0d cycles expected 1", n);
    end
    @(posedge clk);
    if (gap > 0) begin
      @(negedge clk) bus.in_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic load(input int gap);
    foreach (stim[i]) send(stim[i], gap);
    @(negedge clk) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", done, 1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rdy_during_we = 0;
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwrites"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, wr_addr[0], 32'h0);
      check({tag, "_data0"}, wr_data[0], 32'h00A00513);
      check({tag, "_addr1"}, wr_addr[1], 32'h4);
      check({tag, "_data1"}, wr_data[1], 32'h00500593);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_hold"}, core_hold, 0);
    check({tag, "_words"}, words_written, 2);
    check({tag, "_rdy_we"}, rdy_during_we, 0);
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    check("rst_ready", bus.in_ready, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_hold", core_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_written, 0);
    check("rst_addr", bus.mem_addr, 32'h0);

    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    load(0);
    wait_done();
    check_two_word("two");

    clear_log();
    pulse_start();
    check("zero_start_done", done, 0);
    check("zero_start_hold", core_hold, 1);
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk) bus.in_valid = 1'b0;
    check("zero_done", done, 1);
    check("zero_hold", core_hold, 0);
    repeat (3) @(negedge clk);
    check("zero_nwrites", wr_addr.size(), 0);

    clear_log();
    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    @(negedge clk) bus.in_valid = 1'b0;
    check("over_error", error, 1);
    check("over_hold", core_hold, 1);
    check("over_ready", bus.in_ready, 0);
    check("over_done", done, 0);
    repeat (5) @(negedge clk);
    check("over_nwrites", wr_addr.size(), 0);
    pulse_start();
    stim = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    load(0);
    wait_done();
    check("over_rec_error", error, 0);
    check("over_rec_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("over_rec_addr", wr_addr[0], 32'h0);
      check("over_rec_data", wr_data[0], 32'h00A00513);
    end

    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    load(3);
    wait_done();
    check_two_word("gap");

    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05};
    foreach (stim[i]) send(stim[i], 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    check("mid_ready", bus.in_ready, 0);
    check("mid_we", bus.mem_we, 0);
    check("mid_hold", core_hold, 1);
    check("mid_done", done, 0);
    check("mid_error", error, 0);
    check("mid_words", words_written, 0);
    check("mid_addr", bus.mem_addr, 32'h0);
    repeat (10) @(negedge clk);
    check("mid_nwrites", wr_addr.size(), 1);
    clear_log();
    pulse_start();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(0);
    wait_done();
    check("mid_new_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("mid_new_addr", wr_addr[0], 32'h0);
      check("mid_new_data", wr_data[0], 32'hDEADBEEF);
    end
    check("mid_new_words", words_written, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The datapath's instruction fetch only reads memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to instruction memory at consecutive byte addresses (PC-compatible, step 4).
- Holds the core in reset until the load is complete.

Parameters:
- ADDR_W, 32, width of the memory byte address (matches PC width).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.
- MAX_WORDS, 256, instruction memory capacity in words; the length header must not exceed it.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the byte this cycle; a byte transfers when in_valid and in_ready are both 1.
- mem_we  output  1  single-cycle instruction-memory write strobe.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  32  instruction word.
- core_hold  output  1  1 = keep the datapath in reset.
- done  output  1  load completed successfully; level output.
- error  output  1  length header exceeded MAX_WORDS; level output.
- words_written  output  16  number of words written in the current load.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - core_hold=1, done=0, error=0, words_written=0, byte index=0.
  - Reset overrides every other input, including reset asserted mid-load. The partial load is abandoned and no further writes occur.
- States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0. start=1 → LEN0, and the cycle also clears words_written, byte index, done and error, sets mem_addr=BASE_ADDR and core_hold=1.
- LEN0: in_ready=1. An accepted byte becomes len[7:0] → LEN1.
- LEN1: in_ready=1. An accepted byte becomes len[15:8]. Transition on that acceptance:
  - len==0 → DONE.
  - len>MAX_WORDS → ERR.
  - otherwise → DATA.
- DATA: in_ready=1.
  - Accepted bytes fill mem_wdata little-endian: byte index 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24].
  - The 4th accepted byte → WRITE, and the byte index wraps to 0.
- WRITE: exactly one cycle.
  - mem_we=1, mem_addr = BASE_ADDR + 4*words_written, mem_wdata = assembled word.
  - in_ready=0.
  - Next edge: words_written increments. Then → DONE if words_written+1==len, else → DATA.
  - mem_addr advances by 4 after the write (modulo 2^ADDR_W).
- DONE: done=1, core_hold=0, in_ready=0, mem_we=0. start → LEN0 (a restart re-asserts core_hold).
- ERR: error=1, core_hold=1, in_ready=0. No write is ever issued for an oversize header. start → LEN0.
- Write latency: mem_we asserts in the cycle after the 4th byte is accepted.
- Idle cycles (in_valid=0) are allowed anywhere. State, byte index and partial word are held unchanged.
- Bytes presented while in_ready=0 are not consumed. The source must hold them.
- start outside IDLE/DONE/ERR is ignored.
- mem_we is never asserted outside WRITE.
- Maximum throughput: one word per 5 cycles.

Test Plan:
- Reset: hold reset=0 for 2 edges, then release → in_ready=0, mem_we=0, core_hold=1, done=0, error=0, words_written=0, mem_addr=0.
- Two-word load: start, then bytes 02 00 13 05 A0 00 93 05 50 00 with in_valid continuously 1 →
  - Write 1: mem_we at addr 0x0 with data 0x00A00513.
  - Write 2: mem_we at addr 0x4 with data 0x00500593.
  - After that: done=1, core_hold=0, words_written=2.
  - in_ready=0 during each WRITE cycle.
- Zero length: start, bytes 00 00 → DONE on the next edge, done=1, core_hold=0, mem_we never asserted.
- Oversize header (MAX_WORDS=256): start, bytes 01 01 (len=257) → error=1, core_hold=1, in_ready=0, no mem_we. A later start followed by a valid load succeeds and clears error.
- Gapped stream: same stimulus as the two-word load, but with in_valid=0 for 3 cycles between every byte → identical writes, addresses and final state.
- Reset mid-load: after 6 payload bytes (one word written), drive reset=0 for 1 edge →
  - All reset values return and no further mem_we occurs.
  - A new start with a 1-word load writes at addr 0x0.
